// File: rtl/dmem_ctrl.sv
// dmem_ctrl: load/store responder between the execute stage and a
// single-outstanding valid/ready data bus. Computes byte enables, aligns and
// extends load data, holds the pipeline while the access is in flight, and
// reports misaligned requests, slave errors and bus timeouts.
module dmem_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_sz,
  input  logic        req_sx,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_resp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Terminal count of the wait-state counter; TIMEOUT is limited to 16 bits.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q;
  logic [31:0] addr_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [1:0]  sz_q;
  logic        sx_q;
  logic [3:0]  be_q;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic [31:0] rdata_q;
  logic        rdata_valid_q;
  logic        bus_err_q;

  logic        req_misaligned;
  logic [3:0]  req_be;
  logic [31:0] rd_shifted;
  logic [31:0] load_value;

  // Classify the incoming request and derive its byte enables.
  always_comb begin
    req_misaligned = 1'b0;
    req_be         = 4'b0000;
    unique case (req_sz)
      2'd0: req_be = 4'b0001 << req_addr[1:0];
      2'd1: begin
        req_be         = 4'b0011 << {req_addr[1], 1'b0};
        req_misaligned = req_addr[0];
      end
      2'd2: begin
        req_be         = 4'b1111;
        req_misaligned = (req_addr[1:0] != 2'b00);
      end
      default: req_misaligned = 1'b1;
    endcase
  end

  // Align and extend the returned bus word. Accepted accesses are naturally
  // aligned, so shifting by the byte offset lands any field at bit 0.
  always_comb begin
    rd_shifted = bus_rdata >> {addr_q[1:0], 3'b000};
    load_value = rd_shifted;
    unique case (sz_q)
      2'd0:    load_value = {{24{sx_q & rd_shifted[7]}}, rd_shifted[7:0]};
      2'd1:    load_value = {{16{sx_q & rd_shifted[15]}}, rd_shifted[15:0]};
      default: load_value = bus_rdata;
    endcase
  end

  // Wait-state counter increment.
  always_comb begin
    cnt_d = cnt_q + 16'd1;
  end

  // Transaction FSM: request latch, bus handshake, timeout and result registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      sz_q          <= '0;
      sx_q          <= 1'b0;
      be_q          <= '0;
      cnt_q         <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      bus_err_q     <= 1'b0;
    end else begin
      rdata_valid_q <= 1'b0;
      bus_err_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid && !req_misaligned) begin
            addr_q  <= req_addr;
            we_q    <= req_we;
            wdata_q <= req_wdata;
            sz_q    <= req_sz;
            sx_q    <= req_sx;
            be_q    <= req_be;
            cnt_q   <= '0;
            state_q <= BUS;
          end
        end
        BUS: begin
          // A ready on the terminal-count edge still counts as success.
          if (bus_ready) begin
            state_q       <= DONE;
            rdata_valid_q <= 1'b1;
            bus_err_q     <= bus_resp_err;
            if (!bus_resp_err && !we_q) begin
              rdata_q <= load_value;
            end
          end else if (cnt_q == CNT_LAST) begin
            state_q       <= DONE;
            rdata_valid_q <= 1'b1;
            bus_err_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DONE: begin
          // The request still present here is the one just completed.
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stall and misalign react to the request in the same cycle; both are
  // forced low while reset is asserted.
  assign stall     = rstn & ((state_q == BUS) |
                             ((state_q == IDLE) & req_valid & ~req_misaligned));
  assign misalign  = rstn & (state_q == IDLE) & req_valid & req_misaligned;

  assign bus_valid   = (state_q == BUS);
  assign bus_addr    = {addr_q[31:2], 2'b00};
  assign bus_we      = we_q;
  assign bus_be      = be_q;
  assign bus_wdata   = wdata_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed and randomized load/store transactions against a
// transaction-level model of dmem_ctrl (TIMEOUT=4).
module tb_dmem_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_sz;
  logic        req_sx;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        misalign;
  logic        bus_err;
  logic        bus_valid;
  logic        bus_ready;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_resp_err;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_rdata;

  dmem_ctrl #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_sz       (req_sz),
    .req_sx       (req_sx),
    .stall        (stall),
    .rdata        (rdata),
    .rdata_valid  (rdata_valid),
    .misalign     (misalign),
    .bus_err      (bus_err),
    .bus_valid    (bus_valid),
    .bus_ready    (bus_ready),
    .bus_addr     (bus_addr),
    .bus_we       (bus_we),
    .bus_be       (bus_be),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_resp_err (bus_resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One pipeline request; the slave asserts ready in BUS cycle 'waits'
  // (0-based), so waits >= TO never answers and must time out.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [1:0] sz, input logic sx, input logic [31:0] rdat,
                     input int waits, input logic rerr);
    logic        mis;
    logic [3:0]  be;
    logic [31:0] ld;
    logic [7:0]  b8;
    logic [15:0] h16;
    logic        exp_err;
    int          exp_nv;
    int          nv;
    int          stalls;
    logic        done;

    mis = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'b00);
    be  = 4'b0000;
    ld  = 32'h0;
    b8  = rdat[8*addr[1:0] +: 8];
    h16 = rdat[16*addr[1] +: 16];
    case (sz)
      2'd0: begin
        be = 4'b0001 << addr[1:0];
        ld = (sx && b8[7]) ? {24'hFFFFFF, b8} : {24'h0, b8};
      end
      2'd1: begin
        be = (addr[1]) ? 4'b1100 : 4'b0011;
        ld = (sx && h16[15]) ? {16'hFFFF, h16} : {16'h0, h16};
      end
      default: begin
        be = 4'b1111;
        ld = rdat;
      end
    endcase
    exp_err = (waits >= TO) || rerr;
    exp_nv  = (waits < TO) ? waits + 1 : TO;

    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_sz = sz; req_sx = sx; bus_ready = 1'b0; bus_rdata = rdat; bus_resp_err = rerr;
    @(negedge clk);
    $display("txn we=%0d addr=%h sz=%0d sx=%0d waits=%0d rerr=%0d mis=%0d",
             we, addr, sz, sx, waits, rerr, mis);
    check("misalign", 32'(misalign), 32'(mis));
    check("stall_c0", 32'(stall), 32'(!mis));
    check("bus_valid_c0", 32'(bus_valid), 32'd0);
    if (mis) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      check("bus_valid_mis", 32'(bus_valid), 32'd0);
      check("rdata_valid_mis", 32'(rdata_valid), 32'd0);
      check("rdata_mis", rdata, exp_rdata);
      return;
    end

    nv = 0; stalls = 1; done = 1'b0;
    for (int it = 0; it < TO + 4 && !done; it++) begin
      @(posedge clk); #1;
      if (bus_valid) begin
        bus_ready = (nv == waits);
        if (nv == 0) begin
          check("bus_be", 32'(bus_be), 32'(be));
          check("bus_addr", bus_addr, {addr[31:2], 2'b00});
          check("bus_we", 32'(bus_we), 32'(we));
          check("bus_wdata", bus_wdata, wdata);
        end
        nv++;
        @(negedge clk);
        if (stall) stalls++;
      end else begin
        bus_ready = 1'b0;
        @(negedge clk);
        if (!we && !exp_err) exp_rdata = ld;
        check("rdata_valid", 32'(rdata_valid), 32'd1);
        check("bus_err", 32'(bus_err), 32'(exp_err));
        check("stall_done", 32'(stall), 32'd0);
        check("rdata", rdata, exp_rdata);
        done = 1'b1;
      end
    end
    check("done_seen", 32'(done), 32'd1);
    check("bus_valid_cycles", 32'(nv), 32'(exp_nv));
    check("stall_cycles", 32'(stalls), 32'(exp_nv + 1));

    // Request still held across DONE must not be re-issued.
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("no_reissue", 32'(bus_valid), 32'd0);
    check("rdata_valid_idle", 32'(rdata_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  s;

    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_sz = '0; req_sx = 1'b0; bus_ready = 1'b0; bus_rdata = '0; bus_resp_err = 1'b0;
    exp_rdata = 32'h0;
    #2;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_bus_valid", 32'(bus_valid), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_rdata_valid", 32'(rdata_valid), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    #20 rstn = 1'b1;

    // Directed cases
    txn(1'b0, 32'h0000_1003, 32'h0, 2'd0, 1'b1, 32'h8899AABB, 0, 1'b0);
    txn(1'b1, 32'h0000_2002, 32'hBEEFBEEF, 2'd1, 1'b0, 32'h12345678, 0, 1'b0);
    txn(1'b0, 32'h0000_0010, 32'h0, 2'd1, 1'b0, 32'h0000F00D, 3, 1'b0);
    txn(1'b0, 32'h0000_3001, 32'h0, 2'd2, 1'b0, 32'h0, 0, 1'b0);
    txn(1'b0, 32'h0000_4000, 32'h0, 2'd3, 1'b0, 32'h0, 0, 1'b0);
    txn(1'b0, 32'h0000_5000, 32'h0, 2'd2, 1'b0, 32'hDEADBEEF, 10, 1'b0);
    txn(1'b0, 32'h0000_5004, 32'h0, 2'd2, 1'b0, 32'hCAFEF00D, 0, 1'b1);
    txn(1'b0, 32'h0000_6000, 32'h0, 2'd2, 1'b0, 32'hA5A5_5A5A, TO - 1, 1'b0);

    // Reset while the bus access is outstanding
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20; req_sz = 2'd2; req_sx = 1'b0;
    bus_ready = 1'b0;
    @(posedge clk); #1;
    check("bus_valid_before_rst", 32'(bus_valid), 32'd1);
    rstn = 1'b0;
    #1;
    $display("txn async reset mid-BUS");
    check("rst_mid_bus_valid", 32'(bus_valid), 32'd0);
    check("rst_mid_stall", 32'(stall), 32'd0);
    check("rst_mid_rdata", rdata, 32'h0);
    exp_rdata = 32'h0;
    req_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    txn(1'b0, 32'h0000_0008, 32'h0, 2'd2, 1'b0, 32'h1357_9BDF, 0, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      a = $urandom;
      s = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (s == 2'd1) a[0] = 1'b0;
        if (s == 2'd2) a[1:0] = 2'b00;
      end
      txn(1'($urandom_range(0, 1)), a, $urandom, s, 1'($urandom_range(0, 1)), $urandom,
          $urandom_range(0, 5), 1'($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
